eka_icache: RTL and testbench

EKA_ICACHE -- requirements
Module: eka_icache

---
 rtl/eka_icache_pkg.sv | 24 ++
 rtl/eka_icache_data_array.sv | 24 ++
 rtl/eka_icache.sv | 158 +++++++++++++++
 tb/tb_eka_icache.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/eka_icache_pkg.sv
// Shared types, constants and address-width helpers for the eka_icache instruction cache.
package eka_icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_width, input int lines, input int words_per_line);
    return addr_width - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/eka_icache_data_array.sv
// Line data storage: one combinational read port, one synchronous write port, no reset.
module eka_icache_data_array
  import eka_icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                    clk,
  input  logic                                    we,
  input  logic [$clog2(LINES*WORDS_PER_LINE)-1:0] waddr,
  input  logic [31:0]                             wdata,
  input  logic [$clog2(LINES*WORDS_PER_LINE)-1:0] raddr,
  output logic [31:0]                             rdata
);

  logic [31:0] mem_q [LINES*WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/eka_icache.sv
// Direct-mapped instruction cache with zero-latency hits and line refill FSM.
// Optional performance counters enabled by defining EKA_ICACHE_PERF_EN.
module eka_icache
  import eka_icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OW = offset_bits(WORDS_PER_LINE);
  localparam int IW = index_bits(LINES);
  localparam int TW = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE);

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [OW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  flushed_q, flushed_d;
  logic [TW-1:0]         tag_q [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] fill_idx;
  logic [31:0]   rdata;
  logic          hit, miss_event, beat_we, last_beat;
  logic [1:0]    unused_addr_bits;

  assign unused_addr_bits = inst_addr[1:0];
  assign idx      = inst_addr[OW+2 +: IW];
  assign tag      = inst_addr[ADDR_WIDTH-1 -: TW];
  assign fill_idx = mem_addr_q[OW+2 +: IW];

  assign hit        = (state_q == IDLE) && !flush && valid_q[idx] && (tag_q[idx] == tag);
  assign miss_event = (state_q == IDLE) && !flush && !hit;
  assign beat_we    = (state_q == FILL) && mem_rvalid;
  assign last_beat  = beat_we && (&cnt_q);

  assign inst_valid  = hit;
  assign instruction = hit ? rdata : NOP;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  eka_icache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data (
    .clk   (clk),
    .we    (beat_we),
    .waddr ({fill_idx, cnt_q}),
    .wdata (mem_rdata),
    .raddr (inst_addr[2 +: IW+OW]),
    .rdata (rdata)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    flushed_d  = flushed_q;
    case (state_q)
      IDLE: begin
        if (miss_event) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = {inst_addr[ADDR_WIDTH-1:OW+2], {(OW+2){1'b0}}};
          flushed_d  = 1'b0;
        end
      end
      REQ: begin
        flushed_d = flushed_q | flush;
        if (mem_ack) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      FILL: begin
        flushed_d = flushed_q | flush;
        if (beat_we) cnt_d = cnt_q + 1'b1;
        // A flush seen at any point of the refill, including the last beat, keeps the line invalid.
        if (last_beat) begin
          state_d = IDLE;
          if (!flushed_q && !flush) valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      flushed_q  <= flushed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) tag_q[fill_idx] <= mem_addr_q[ADDR_WIDTH-1 -: TW];
  end

`ifdef EKA_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && !(&hit_cnt_q))          hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_event && !(&miss_cnt_q))  miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_eka_icache.sv
// Directed table-driven bench for eka_icache with hand sequences for refill corner cases.
module tb_eka_icache;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk, reset, flush, mem_ack, mem_rvalid;
  logic [31:0] inst_addr, mem_rdata;
  logic [31:0] instruction, mem_addr, hit_count, miss_count;
  logic        inst_valid, mem_req;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[5];

  eka_icache dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill(input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] beats [4];
    beats = '{d0, d1, d2, d3};
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beats[i];
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    logic [31:0] exp_hits, exp_miss;
    vecs[0] = '{32'h0000_0004, 1'b0, 1'b1, 32'h0000_0022};
    vecs[1] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0011};
    vecs[2] = '{32'h0000_000C, 1'b0, 1'b1, 32'h0000_0044};
    vecs[3] = '{32'h0000_0008, 1'b0, 1'b1, 32'h0000_0033};
    vecs[4] = '{32'h0000_0004, 1'b1, 1'b0, NOP_W};

    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; inst_addr = 32'h0;
    @(negedge clk);
    check("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);

    // Cold miss at address 0 then refill.
    reset = 1'b0;
    #1;
    check("cold_valid", {31'b0, inst_valid}, 32'd0);
    check("cold_instr_nop", instruction, NOP_W);
    step();
    check("cold_mem_req", {31'b0, mem_req}, 32'd1);
    check("cold_mem_addr", mem_addr, 32'h0);
    fill(32'h11, 32'h22, 32'h33, 32'h44);
    #1;
    check("fill0_valid", {31'b0, inst_valid}, 32'd1);
    check("fill0_instr", instruction, 32'h11);
    check("fill0_no_req", {31'b0, mem_req}, 32'd0);
    step();
    inst_addr = 32'h8; #1;
    check("hit8_valid", {31'b0, inst_valid}, 32'd1);
    check("hit8_instr", instruction, 32'h33);
    step();
    inst_addr = 32'hC; #1;
    check("hitC_valid", {31'b0, inst_valid}, 32'd1);
    check("hitC_instr", instruction, 32'h44);
    check("hitC_no_req", {31'b0, mem_req}, 32'd0);
    step();
`ifdef EKA_ICACHE_PERF_EN
    exp_hits = 32'd3; exp_miss = 32'd1;
`else
    exp_hits = 32'd0; exp_miss = 32'd0;
`endif
    check("perf_hit_count", hit_count, exp_hits);
    check("perf_miss_count", miss_count, exp_miss);

    for (int i = 0; i < 5; i++) begin
      inst_addr = vecs[i].addr;
      flush     = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
      check($sformatf("vec%0d_no_req", i), {31'b0, mem_req}, 32'd0);
      step();
      flush = 1'b0;
    end

    // Flush in IDLE must not have started a refill; the line is now invalid.
    inst_addr = 32'h0; #1;
    check("postflush_no_req", {31'b0, mem_req}, 32'd0);
    check("postflush_valid", {31'b0, inst_valid}, 32'd0);
    step();
    // Hold ack low five cycles with stray beats; request must stay stable.
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_0000 + i;
      check($sformatf("stall%0d_req", i), {31'b0, mem_req}, 32'd1);
      check($sformatf("stall%0d_addr", i), mem_addr, 32'h0);
      step();
    end
    mem_rvalid = 1'b0;
    fill(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    #1;
    check("stall_fill_instr0", instruction, 32'hA1);
    step();
    inst_addr = 32'h4; #1;
    check("stall_fill_instr1", instruction, 32'hA2);
    step();

    // Same index, different tag; live address wanders during refill.
    inst_addr = 32'h100; #1;
    check("conflict_valid", {31'b0, inst_valid}, 32'd0);
    step();
    check("conflict_mem_addr", mem_addr, 32'h100);
    inst_addr = 32'h40;
    fill(32'hB1, 32'hB2, 32'hB3, 32'hB4);
    inst_addr = 32'h104; #1;
    check("conflict_instr", instruction, 32'hB2);
    check("conflict_hit", {31'b0, inst_valid}, 32'd1);
    step();
    inst_addr = 32'h0; #1;
    check("evicted_valid", {31'b0, inst_valid}, 32'd0);
    step();
    check("evicted_mem_req", {31'b0, mem_req}, 32'd1);
    check("evicted_mem_addr", mem_addr, 32'h0);

    // Flush coincident with the last beat keeps the line invalid.
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0 + i;
      flush      = (i == 3);
      step();
    end
    mem_rvalid = 1'b0; flush = 1'b0; #1;
    check("lastflush_valid", {31'b0, inst_valid}, 32'd0);
    check("lastflush_instr", instruction, NOP_W);
    step();
    check("lastflush_remiss_req", {31'b0, mem_req}, 32'd1);

    // Reset mid-REQ abandons the refill.
    reset = 1'b1; #1;
    check("midreset_req", {31'b0, mem_req}, 32'd0);
    check("midreset_addr", mem_addr, 32'h0);
    check("midreset_hit_count", hit_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
